// File: rtl/keccak_cmd_sequencer.sv
// Purpose: queued command sequencer for the Keccak core. It drives the core
//          controls and multiplexes the shared BRAM between the core and the
//          external loader.
// Latency: a push into an empty idle queue at cycle t is popped at t+1.
//          CLEAR or RUN starts at t+2. cmd_done follows core_done by one cycle.
// Backpressure: cmd_ready is low while the queue holds CMD_DEPTH entries. It
//          comes from the registered level only, so a push at full is refused
//          even on a pop cycle.
//
// Ports:
//   clk, rst                        single clock, synchronous active-high reset
//   cmd_w0/cmd_w1/cmd_valid/ready   command push interface; word0 is
//                                   {OP3, OP2, OP1, INS} and word1 is {olen, mlen}
//   fifo_level, busy, cmd_done, err status; err is sticky and cleared by err_clr
//   ext_*                           external BRAM loader port
//   bram_*                          BRAM port A (read/write) and port B (read)
//   core_*                          Keccak core controls and status
//
// Optional feature: define KECCAK_SEQ_TIMEOUT_EN to enable the RUN watchdog,
// which is limited by TIMEOUT_CYCLES.
module keccak_cmd_sequencer #(
    parameter int AW             = 9,
    parameter int DW             = 64,
    parameter int LEN_W          = 16,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [5+3*AW-1:0]           cmd_w0,
    input  logic [2*LEN_W-1:0]          cmd_w1,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    output logic [$clog2(CMD_DEPTH):0]  fifo_level,
    output logic                        busy,
    output logic                        cmd_done,
    output logic [1:0]                  err,
    input  logic                        err_clr,
    input  logic [AW-1:0]               ext_addr,
    input  logic [DW-1:0]               ext_din,
    input  logic                        ext_we,
    output logic                        bram_wea,
    output logic [AW-1:0]               bram_addra,
    output logic [DW-1:0]               bram_dina,
    output logic [AW-1:0]               bram_addrb,
    output logic                        core_clear,
    output logic                        core_enable,
    output logic                        core_int_rst,
    output logic                        core_next_extract,
    output logic [1:0]                  core_rate_type,
    output logic [LEN_W-1:0]            core_mlen,
    output logic [LEN_W-1:0]            core_olen,
    input  logic [AW-1:0]               core_rd_addr,
    input  logic [AW-1:0]               core_wt_addr,
    input  logic [DW-1:0]               core_dout,
    input  logic                        core_sample,
    input  logic                        core_done
);
    localparam int W0_W  = 5 + 3 * AW;
    localparam int W1_W  = 2 * LEN_W;
    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [W0_W-1:0]   fifo_w0_q [CMD_DEPTH];
    logic [W1_W-1:0]   fifo_w1_q [CMD_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic [W0_W-1:0]   cur_w0_q;
    logic [W1_W-1:0]   cur_w1_q;
    logic [1:0]        err_q, err_d;
    logic              first_q;   // first RUN cycle: ignore a possibly stale core_done
    logic              push, pop, ill_ins, tmo_err;
    logic [4:0]        head_ins, ins;
    logic [AW-1:0]     op1, op2, op3;

    assign push     = cmd_valid && cmd_ready;
    assign head_ins = fifo_w0_q[rd_ptr_q][4:0];
    assign ins      = cur_w0_q[4:0];
    assign op1      = cur_w0_q[5 +: AW];
    assign op2      = cur_w0_q[5+AW +: AW];
    assign op3      = cur_w0_q[5+2*AW +: AW];

`ifdef KECCAK_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q;

    // The count is zero on the first RUN cycle, so the limit is hit on RUN cycle TIMEOUT_CYCLES.
    always_ff @(posedge clk) begin
        if (rst || state_q != S_RUN) tmo_cnt_q <= '0;
        else                         tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

    // OP2 travels with the command but has no consumer in this block.
    logic unused_op2;
    assign unused_op2 = ^op2;

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        ill_ins     = 1'b0;
        tmo_err     = 1'b0;
        core_clear  = rst;
        core_enable = 1'b0;
        cmd_done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    pop = 1'b1;
                    if (head_ins == 5'd0)      state_d = S_CLEAR;
                    else if (head_ins <= 5'd5) state_d = S_RUN;
                    else begin
                        ill_ins = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_CLEAR: begin
                core_clear = 1'b1;
                state_d    = S_DONE;
            end
            S_RUN: begin
                core_enable = 1'b1;
                if (!first_q && core_done) state_d = S_DONE;
`ifdef KECCAK_SEQ_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    core_clear = 1'b1;
                    tmo_err    = 1'b1;
                    state_d    = S_DONE;
                end
`endif
            end
            S_DONE: begin
                cmd_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A new error in the same cycle as err_clr wins.
        err_d = err_clr ? 2'b00 : err_q;
        if (ill_ins)          err_d[0] = 1'b1;
        if (ext_we && busy)   err_d[1] = 1'b1;
        if (tmo_err)          err_d[1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            err_q    <= 2'b00;
            first_q  <= 1'b1;
            cur_w0_q <= '0;
            cur_w1_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            first_q <= (state_q != S_RUN);
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                cur_w0_q <= fifo_w0_q[rd_ptr_q];
                cur_w1_q <= fifo_w1_q[rd_ptr_q];
            end
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (!push && pop) level_q <= level_q - 1'b1;
        end
    end

    // Queue storage needs no reset; the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_w0_q[wr_ptr_q] <= cmd_w0;
            fifo_w1_q[wr_ptr_q] <= cmd_w1;
        end
    end

    assign cmd_ready  = (level_q != LVL_W'(CMD_DEPTH));
    assign fifo_level = level_q;
    assign busy       = (state_q != S_IDLE) || (level_q != '0);
    assign err        = err_q;

    assign core_int_rst      = (ins == 5'd4);
    assign core_next_extract = (ins == 5'd5);
    assign core_rate_type    = (ins == 5'd1) ? 2'd1 : (ins == 5'd2) ? 2'd0 : 2'd2;
    assign core_mlen         = cur_w1_q[LEN_W-1:0];
    assign core_olen         = cur_w1_q[2*LEN_W-1:LEN_W];

    // The core owns the BRAM only while RUN. Otherwise the loader owns it, but its writes are held off while busy.
    assign bram_wea   = (state_q == S_RUN) ? core_sample : (ext_we && !busy);
    assign bram_dina  = (state_q == S_RUN) ? core_dout : ext_din;
    assign bram_addra = (state_q == S_RUN) ? core_wt_addr + op3 : ext_addr;
    assign bram_addrb = (state_q == S_RUN) ? core_rd_addr + op1 : ext_addr;

endmodule

// File: tb/tb_keccak_cmd_sequencer.sv
// Self-checking bench for keccak_cmd_sequencer. It uses a decode table plus
// hand-written multi-cycle sequences.
module tb_keccak_cmd_sequencer;
    localparam int AW = 9, DW = 64, LEN_W = 16, CMD_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [5+3*AW-1:0] cmd_w0;
    logic [2*LEN_W-1:0] cmd_w1;
    logic              cmd_valid, cmd_ready;
    logic [2:0]        fifo_level;
    logic              busy, cmd_done, err_clr;
    logic [1:0]        err;
    logic [AW-1:0]     ext_addr, bram_addra, bram_addrb, core_rd_addr, core_wt_addr;
    logic [DW-1:0]     ext_din, bram_dina, core_dout;
    logic              ext_we, bram_wea;
    logic              core_clear, core_enable, core_int_rst, core_next_extract;
    logic [1:0]        core_rate_type;
    logic [LEN_W-1:0]  core_mlen, core_olen;
    logic              core_sample, core_done;

    keccak_cmd_sequencer #(.AW(AW), .DW(DW), .LEN_W(LEN_W), .CMD_DEPTH(CMD_DEPTH),
                           .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .cmd_w0(cmd_w0), .cmd_w1(cmd_w1), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .fifo_level(fifo_level), .busy(busy), .cmd_done(cmd_done),
        .err(err), .err_clr(err_clr), .ext_addr(ext_addr), .ext_din(ext_din), .ext_we(ext_we),
        .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
        .bram_addrb(bram_addrb), .core_clear(core_clear), .core_enable(core_enable),
        .core_int_rst(core_int_rst), .core_next_extract(core_next_extract),
        .core_rate_type(core_rate_type), .core_mlen(core_mlen), .core_olen(core_olen),
        .core_rd_addr(core_rd_addr), .core_wt_addr(core_wt_addr), .core_dout(core_dout),
        .core_sample(core_sample), .core_done(core_done));

    always #5 clk = ~clk;

    int pass_cnt = 0, total_cnt = 0;
    int done_cnt = 0, clr_cnt = 0;
    logic [LEN_W-1:0] done_mlen [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_done) begin
                done_cnt++;
                done_mlen.push_back(core_mlen);
            end
            if (core_clear) clr_cnt++;
        end
    end

    localparam int K_CLR = 0, K_RUN = 1, K_ILL = 2;
    typedef struct {
        logic [4:0] ins;
        int         kind;
        logic [1:0] rate;
        logic       irst;
        logic       nx;
        int         clr;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5+3*AW-1:0] mk_w0(input logic [4:0] ins, input logic [AW-1:0] op1,
                                                 input logic [AW-1:0] op3);
        return {op3, 9'd0, op1, ins};
    endfunction

    task automatic push(input logic [5+3*AW-1:0] w0, input logic [2*LEN_W-1:0] w1);
        cmd_w0 = w0; cmd_w1 = w1; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string nm);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            step();
            n++;
        end
        chk(nm, done_cnt, target);
    endtask

    initial begin
        tbl[0] = '{5'd0, K_CLR, 2'd2, 1'b0, 1'b0, 1};
        tbl[1] = '{5'd1, K_RUN, 2'd1, 1'b0, 1'b0, 0};
        tbl[2] = '{5'd2, K_RUN, 2'd0, 1'b0, 1'b0, 0};
        tbl[3] = '{5'd3, K_RUN, 2'd2, 1'b0, 1'b0, 0};
        tbl[4] = '{5'd4, K_RUN, 2'd2, 1'b1, 1'b0, 0};
        tbl[5] = '{5'd5, K_RUN, 2'd2, 1'b0, 1'b1, 0};
        tbl[6] = '{5'd6, K_ILL, 2'd2, 1'b0, 1'b0, 0};
        tbl[7] = '{5'd7, K_ILL, 2'd2, 1'b0, 1'b0, 0};

        rst = 1'b1; cmd_w0 = '0; cmd_w1 = '0; cmd_valid = 1'b0; err_clr = 1'b0;
        ext_addr = '0; ext_din = '0; ext_we = 1'b0; core_rd_addr = '0; core_wt_addr = '0;
        core_dout = '0; core_sample = 1'b0; core_done = 1'b0;
        step(); step();
        chk("rst_core_clear", core_clear, 1);
        chk("rst_core_enable", core_enable, 0);
        rst = 1'b0;
        step();
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_done", cmd_done, 0);
        chk("rst_clear_low", core_clear, 0);

        // External write while idle, then one INS=1 command with OP3=16.
        ext_addr = 9'd3; ext_din = 64'hA5A5_0000_0000_0001; ext_we = 1'b1; #1;
        chk("ext_wea", bram_wea, 1);
        chk("ext_addra", bram_addra, 3);
        chk("ext_addrb", bram_addrb, 3);
        chk("ext_dina", bram_dina, 64'hA5A5_0000_0000_0001);
        step();
        ext_we = 1'b0;
        chk("ext_no_err", err, 0);
        done_cnt = 0;
        push(mk_w0(5'd1, 9'd0, 9'd16), {16'd32, 16'd32});
        chk("q1_level", fifo_level, 1);
        chk("q1_busy", busy, 1);
        step();
        chk("q1_enable", core_enable, 1);
        chk("q1_rate", core_rate_type, 1);
        chk("q1_mlen", core_mlen, 32);
        chk("q1_olen", core_olen, 32);
        core_wt_addr = 9'd5; core_rd_addr = 9'd7; core_sample = 1'b1;
        core_dout = 64'h1234_5678_9ABC_DEF0; #1;
        chk("q1_addra", bram_addra, 21);
        chk("q1_addrb", bram_addrb, 7);
        chk("q1_wea", bram_wea, 1);
        chk("q1_dina", bram_dina, 64'h1234_5678_9ABC_DEF0);
        step();
        core_done = 1'b1; #1;
        chk("q1_no_early_done", cmd_done, 0);
        step();
        chk("q1_done", cmd_done, 1);
        chk("q1_enable_off", core_enable, 0);
        chk("q1_busy_in_done", busy, 1);
        core_done = 1'b0; core_sample = 1'b0;
        step();
        chk("q1_busy_clear", busy, 0);
        chk("q1_done_count", done_cnt, 1);

        // Mode decode and retire behaviour for every INS.
        for (int i = 0; i < 8; i++) begin
            done_cnt = 0; clr_cnt = 0;
            push(mk_w0(tbl[i].ins, 9'd0, 9'd0), {16'(i + 100), 16'(i)});
            step();
            chk($sformatf("tbl%0d_rate", i), core_rate_type, tbl[i].rate);
            chk($sformatf("tbl%0d_irst", i), core_int_rst, tbl[i].irst);
            chk($sformatf("tbl%0d_nx", i), core_next_extract, tbl[i].nx);
            chk($sformatf("tbl%0d_olen", i), core_olen, i + 100);
            if (tbl[i].kind == K_CLR) begin
                chk($sformatf("tbl%0d_clear", i), core_clear, 1);
                chk($sformatf("tbl%0d_en", i), core_enable, 0);
                step();
                chk($sformatf("tbl%0d_done", i), cmd_done, 1);
                step();
            end else if (tbl[i].kind == K_RUN) begin
                chk($sformatf("tbl%0d_en", i), core_enable, 1);
                step();
                core_done = 1'b1;
                step();
                chk($sformatf("tbl%0d_done", i), cmd_done, 1);
                core_done = 1'b0;
                step();
            end else begin
                chk($sformatf("tbl%0d_done", i), cmd_done, 1);
                chk($sformatf("tbl%0d_err0", i), err[0], 1);
                err_clr = 1'b1;
                step();
                err_clr = 1'b0;
                chk($sformatf("tbl%0d_err_clr", i), err, 0);
            end
            chk($sformatf("tbl%0d_idle", i), busy, 0);
            chk($sformatf("tbl%0d_ndone", i), done_cnt, 1);
            chk($sformatf("tbl%0d_nclr", i), clr_cnt, tbl[i].clr);
        end

        // Five pushes with the core stalled, plus one refused push at full.
        done_cnt = 0; done_mlen.delete();
        for (int k = 0; k < 5; k++) begin
            cmd_w0 = mk_w0(5'd1, 9'd0, 9'd0); cmd_w1 = {16'd0, 16'(k + 1)}; cmd_valid = 1'b1;
            step();
        end
        cmd_valid = 1'b0;
        chk("full_level", fifo_level, 4);
        chk("full_ready", cmd_ready, 0);
        chk("full_head_mlen", core_mlen, 1);
        push(mk_w0(5'd1, 9'd0, 9'd0), {16'd0, 16'd99});
        chk("full_refused", fifo_level, 4);
        core_done = 1'b1;
        wait_done(5, 60, "full_drain");
        core_done = 1'b0;
        repeat (3) step();
        chk("full_no_extra", done_cnt, 5);
        chk("full_idle", busy, 0);
        for (int k = 0; k < 5; k++)
            chk($sformatf("full_order%0d", k), (k < done_mlen.size()) ? done_mlen[k] : 16'hFFFF, k + 1);

        // Illegal INS followed by CLEAR.
        done_cnt = 0; clr_cnt = 0;
        push(mk_w0(5'd7, 9'd0, 9'd0), '0);
        push(mk_w0(5'd0, 9'd0, 9'd0), '0);
        repeat (10) step();
        chk("ill_clr_ndone", done_cnt, 2);
        chk("ill_clr_nclear", clr_cnt, 1);
        chk("ill_clr_err0", err[0], 1);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("ill_clr_errclr", err, 0);

        // core_done held high across DONE -> IDLE -> RUN.
        done_cnt = 0; core_done = 1'b1;
        push(mk_w0(5'd1, 9'd0, 9'd0), '0);
        push(mk_w0(5'd2, 9'd0, 9'd0), '0);
        chk("hold_a_guard", cmd_done, 0);
        chk("hold_a_en", core_enable, 1);
        step();
        chk("hold_a_run2", cmd_done, 0);
        step();
        chk("hold_a_done", cmd_done, 1);
        step();
        chk("hold_idle_en", core_enable, 0);
        step();
        chk("hold_b_en", core_enable, 1);
        chk("hold_b_rate", core_rate_type, 0);
        chk("hold_b_guard", cmd_done, 0);
        step();
        chk("hold_b_run2", cmd_done, 0);
        chk("hold_b_en2", core_enable, 1);
        step();
        chk("hold_b_done", cmd_done, 1);
        core_done = 1'b0;
        step();
        chk("hold_ndone", done_cnt, 2);

        // External write during RUN.
        done_cnt = 0;
        push(mk_w0(5'd3, 9'd0, 9'd0), '0);
        step();
        ext_addr = 9'd9; ext_we = 1'b1; core_sample = 1'b0; #1;
        chk("coll_wea_blocked", bram_wea, 0);
        core_sample = 1'b1; #1;
        chk("coll_wea_core", bram_wea, 1);
        chk("coll_addra_core", bram_addra, 5);
        step();
        chk("coll_err1", err[1], 1);
        err_clr = 1'b1;
        step();
        chk("coll_err_wins", err[1], 1);
        ext_we = 1'b0;
        step();
        err_clr = 1'b0;
        chk("coll_err_clr", err, 0);
        core_sample = 1'b0; core_done = 1'b1;
        wait_done(1, 10, "coll_retire");
        core_done = 1'b0;
        step();

        // Reset in the middle of RUN with two commands queued.
        done_cnt = 0;
        push(mk_w0(5'd1, 9'd0, 9'd0), '0);
        push(mk_w0(5'd1, 9'd0, 9'd0), '0);
        push(mk_w0(5'd1, 9'd0, 9'd0), '0);
        chk("mrst_level_pre", fifo_level, 2);
        chk("mrst_run_pre", core_enable, 1);
        rst = 1'b1; #1;
        chk("mrst_clear", core_clear, 1);
        step();
        rst = 1'b0; #1;
        chk("mrst_level", fifo_level, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_enable", core_enable, 0);
        chk("mrst_done", cmd_done, 0);
        repeat (3) step();
        chk("mrst_no_done", done_cnt, 0);

`ifdef KECCAK_SEQ_TIMEOUT_EN
        begin
            int n = 0;
            done_cnt = 0; clr_cnt = 0;
            push(mk_w0(5'd1, 9'd0, 9'd0), '0);
            while (!cmd_done && n < 40) begin
                if (core_enable) n++;
                step();
            end
            chk("tmo_run_cycles", n, 8);
            chk("tmo_done", cmd_done, 1);
            chk("tmo_err1", err[1], 1);
            chk("tmo_clear", clr_cnt, 1);
            step();
            chk("tmo_idle", busy, 0);
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
